// File: rtl/ring_counter_monitor_if.sv
// Ring bus sample port and monitor status outputs.
// master drives the samples; slave is the monitor side.
interface ring_counter_monitor_if #(
    parameter int N     = 4,
    parameter int REV_W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic             en;
    logic [N-1:0]     ring_in;
    logic [IW-1:0]    idx;
    logic             idx_valid;
    logic             locked;
    logic             err;
    logic [REV_W-1:0] rev_cnt;
    logic             rev_tick;

    modport master (
        output en, ring_in,
        input  idx, idx_valid, locked, err, rev_cnt, rev_tick
    );

    modport slave (
        input  en, ring_in,
        output idx, idx_valid, locked, err, rev_cnt, rev_tick
    );
endinterface

// File: rtl/ring_counter_monitor.sv
// One-hot ring sequence health monitor with lock tracking and revolution count.
// Optional RING_MON_STICKY_ERR_EN: sticky err and absorbing FAULT state.
module ring_counter_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8
) (
    input logic                   clk,
    input logic                   clear,
    ring_counter_monitor_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     prev_q, prev_d;
    logic [CW-1:0]    good_cnt_q, good_cnt_d;
    logic [CW-1:0]    cnt_inc;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    enc;
    logic             err_q, err_d;
    logic             tick_q, tick_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic             oh;
    logic             good;
    logic             wrap;
    logic             accept;

    always_comb begin
        enc = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.ring_in[k]) enc = IW'(k);
        end
    end

    // Expected word is prev rotated right by one place
    assign oh      = $onehot(bus.ring_in);
    assign good    = oh && (bus.ring_in == {prev_q[0], prev_q[N-1:1]});
    assign wrap    = good && prev_q[0];
    assign cnt_inc = good_cnt_q + CW'(1);

`ifdef RING_MON_STICKY_ERR_EN
    assign accept = (state_q != FAULT);
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            good_cnt_q <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            rev_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_cnt_q <= good_cnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            rev_q      <= rev_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        good_cnt_d = good_cnt_q;
        idx_d      = idx_q;
        rev_d      = rev_q;
        tick_d     = 1'b0;
`ifdef RING_MON_STICKY_ERR_EN
        err_d      = err_q;
`else
        err_d      = 1'b0;
`endif
        if (bus.en) begin
            if (oh && accept) begin
                prev_d = bus.ring_in;
                idx_d  = enc;
            end
            unique case (state_q)
                IDLE: begin
                    if (oh) begin
                        state_d    = SYNC;
                        good_cnt_d = '0;
                    end else begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
                end
                SYNC: begin
                    if (good) begin
                        good_cnt_d = cnt_inc;
                        if (cnt_inc == CW'(LOCK_CNT))
                            state_d = LOCKED;
                    end else if (oh) begin
                        good_cnt_d = '0;
                    end else begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        if (wrap) begin
                            rev_d  = rev_q + REV_W'(1);
                            tick_d = 1'b1;
                        end
                    end else begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
                end
                FAULT: begin
`ifndef RING_MON_STICKY_ERR_EN
                    if (oh) begin
                        state_d    = SYNC;
                        good_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
`ifdef RING_MON_STICKY_ERR_EN
            if (state_d == FAULT) idx_d = '0;
`endif
        end
    end

    always_comb begin
        bus.idx       = idx_q;
        bus.idx_valid = (state_q == SYNC) || (state_q == LOCKED);
        bus.locked    = (state_q == LOCKED);
        bus.err       = err_q;
        bus.rev_cnt   = rev_q;
        bus.rev_tick  = tick_q;
    end

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Self-checking bench for ring_counter_monitor: directed plan then random.
// Reference model tracks the ring as a bit position with modular arithmetic.
module tb_ring_counter_monitor;
    localparam int N        = 4;
    localparam int LOCK_CNT = 2;
    localparam int REV_W    = 8;

    logic clk   = 1'b0;
    logic clear = 1'b1;

    ring_counter_monitor_if #(.N(N), .REV_W(REV_W)) bus ();

    ring_counter_monitor #(
        .N(N),
        .LOCK_CNT(LOCK_CNT),
        .REV_W(REV_W)
    ) dut (
        .clk(clk),
        .clear(clear),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_chk = 0;
    int n_bad = 0;

    // model: mode 0 idle, 1 sync, 2 locked, 3 fault; m_p = last position or -1
    int               m_mode = 0;
    int               m_p    = -1;
    int               m_cnt  = 0;
    logic [1:0]       e_idx  = '0;
    logic             e_err  = 1'b0;
    logic             e_tick = 1'b0;
    logic [REV_W-1:0] e_rev  = '0;

    task automatic model(input logic c, input logic e, input logic [N-1:0] r);
        int  pos;
        int  ones;
        bit  oh;
        bit  good;
        bit  wrap;
        bit  sticky;
`ifdef RING_MON_STICKY_ERR_EN
        sticky = 1;
`else
        sticky = 0;
`endif
        if (c) begin
            m_mode = 0; m_p = -1; m_cnt = 0;
            e_idx = '0; e_err = 1'b0; e_rev = '0; e_tick = 1'b0;
            return;
        end
        e_tick = 1'b0;
        if (!sticky) e_err = 1'b0;
        if (!e) return;
        if (sticky && m_mode == 3) return;
        ones = 0;
        pos  = -1;
        for (int k = 0; k < N; k++) begin
            if (r[k]) begin
                ones++;
                pos = k;
            end
        end
        oh   = (ones == 1);
        good = oh && (m_p >= 0) && (pos == (m_p + N - 1) % N);
        wrap = good && (m_p == 0);
        if (oh) begin
            m_p   = pos;
            e_idx = 2'(pos);
        end
        case (m_mode)
            0: if (oh) begin m_mode = 1; m_cnt = 0; end
               else begin m_mode = 3; e_err = 1'b1; end
            1: if (good) begin
                   m_cnt++;
                   if (m_cnt == LOCK_CNT) m_mode = 2;
               end else if (oh) m_cnt = 0;
               else begin m_mode = 3; e_err = 1'b1; end
            2: if (good) begin
                   if (wrap) begin e_rev++; e_tick = 1'b1; end
               end else begin m_mode = 3; e_err = 1'b1; end
            default:
               if (oh) begin m_mode = 1; m_cnt = 0; end
               else e_err = 1'b1;
        endcase
        if (sticky && m_mode == 3) e_idx = '0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c, input logic e, input logic [N-1:0] r);
        @(negedge clk);
        clear       = c;
        bus.en      = e;
        bus.ring_in = r;
        @(posedge clk);
        model(c, e, r);
        #1;
        n_vec++;
        chk("idx", 8'(bus.idx), 8'(e_idx));
        chk("idx_valid", 8'(bus.idx_valid), 8'(m_mode == 1 || m_mode == 2));
        chk("locked", 8'(bus.locked), 8'(m_mode == 2));
        chk("err", 8'(bus.err), 8'(e_err));
        chk("rev_cnt", 8'(bus.rev_cnt), 8'(e_rev));
        chk("rev_tick", 8'(bus.rev_tick), 8'(e_tick));
    endtask

    initial begin
        logic [N-1:0] v;
        int           rr;
        bus.en      = 1'b0;
        bus.ring_in = '0;

        step(1, 0, 4'b0000);
        step(1, 1, 4'b1000);
        chk("clr_prio", 8'(bus.idx_valid), 8'd0);

`ifndef RING_MON_STICKY_ERR_EN
        step(0, 1, 4'b1000);
        chk("lk_idx3", 8'(bus.idx), 8'd3);
        step(0, 1, 4'b0100);
        step(0, 1, 4'b0010);
        chk("lk_locked", 8'(bus.locked), 8'd1);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b1000);
        chk("rev1_tick", 8'(bus.rev_tick), 8'd1);
        chk("rev1_cnt", 8'(bus.rev_cnt), 8'd1);
        for (int i = 0; i < 8; i++) step(0, 1, 4'b1000 >> ((i + 1) % 4));
        chk("rev3_cnt", 8'(bus.rev_cnt), 8'd3);
        step(0, 1, 4'b0110);
        chk("flt_err", 8'(bus.err), 8'd1);
        step(0, 1, 4'b0100);
        chk("flt_err_drop", 8'(bus.err), 8'd0);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0001);
        chk("flt_relock", 8'(bus.locked), 8'd1);
        chk("flt_rev", 8'(bus.rev_cnt), 8'd3);
        step(1, 0, 4'b0000);
        step(0, 1, 4'b1000);
        step(0, 1, 4'b0010);
        chk("rs_noerr", 8'(bus.err), 8'd0);
        step(0, 1, 4'b0001);
        chk("rs_notlk", 8'(bus.locked), 8'd0);
        step(0, 1, 4'b1000);
        chk("rs_locked", 8'(bus.locked), 8'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 4'b1111);
        step(0, 1, 4'b0000);
        chk("zero_err", 8'(bus.err), 8'd1);
        step(0, 1, 4'b1000);
        step(0, 1, 4'b0100);
        step(0, 1, 4'b0010);
        step(1, 1, 4'b0001);
        chk("clr_locked", 8'(bus.locked), 8'd0);
`else
        step(0, 1, 4'b1000);
        step(0, 1, 4'b0100);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0110);
        step(0, 1, 4'b0100);
        step(0, 1, 4'b0010);
        chk("st_err", 8'(bus.err), 8'd1);
        chk("st_valid", 8'(bus.idx_valid), 8'd0);
        step(1, 1, 4'b1000);
        chk("st_clr", 8'(bus.err), 8'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            rr = int'($urandom_range(0, 99));
            if (m_p >= 0 && rr < 65) v = 4'(1 << ((m_p + N - 1) % N));
            else if (rr < 80) v = 4'(1 << $urandom_range(0, N - 1));
            else v = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
